// File: rtl/adc_forward_ctrl_pkg.sv
// Shared types and constants for the ADC forwarding controller: FSM state
// encoding, default widths and the stimulus-status step helper.
package adc_forward_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int STATUS_W   = 2;
  localparam int CNT_W      = 8;
  localparam int COUNT_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_REQ     = 3'd4
  } state_t;

  // The stimulus status is expected to advance by one per sample, wrapping 3->0.
  function automatic logic [STATUS_W-1:0] status_next(input logic [STATUS_W-1:0] s);
    return s + STATUS_W'(1);
  endfunction

endpackage

// File: rtl/adc_err_sat.sv
// Combinational error path: unsigned subtract widened by one bit, clamp to the
// signed DATA_W range, then compare the clamped value against +/-ERR_LIMIT.
module adc_err_sat #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] ERR_LIMIT = DATA_W'(4)
) (
  input  logic [DATA_W-1:0] i_v_actual,
  input  logic [DATA_W-1:0] i_v_signal,
  output logic [DATA_W-1:0] o_error,
  output logic              o_over,
  output logic              o_under
);

  localparam logic signed [DATA_W-1:0] LIM_POS = ERR_LIMIT;
  localparam logic signed [DATA_W-1:0] LIM_NEG = -LIM_POS;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_err;

  // The top two diff bits disagree exactly when the result leaves the DATA_W range.
  always_comb begin
    w_diff = {1'b0, i_v_actual} - {1'b0, i_v_signal};
    if (w_diff[DATA_W] && !w_diff[DATA_W-1]) begin
      w_err = SAT_MIN;
    end else if (!w_diff[DATA_W] && w_diff[DATA_W-1]) begin
      w_err = SAT_MAX;
    end else begin
      w_err = w_diff[DATA_W-1:0];
    end
  end

  assign o_error = w_err;
  assign o_over  = ($signed(w_err) > LIM_POS);
  assign o_under = ($signed(w_err) < LIM_NEG);

endmodule

// File: rtl/adc_forward_ctrl.sv
// Consumer stage for the ADC stimulus pair: settle, capture, forward the
// saturated error over valid/ready, then pulse req_next to advance the stimulus.
module adc_forward_ctrl
  import adc_forward_ctrl_pkg::*;
#(
  parameter int                DATA_W        = DATA_W_DEF,
  parameter int                SETTLE_CYCLES = 4,
  parameter int                REQ_PULSE     = 2,
  parameter logic [DATA_W-1:0] ERR_LIMIT     = DATA_W'(4)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [DATA_W-1:0]   i_v_actual,
  input  logic [DATA_W-1:0]   i_v_signal,
  input  logic [STATUS_W-1:0] i_stim_state,
  output logic                o_req_next,
  output logic                o_fwd_valid,
  input  logic                i_fwd_ready,
  output logic [DATA_W-1:0]   o_fwd_error,
  output logic                o_fwd_over,
  output logic                o_fwd_under,
  output logic [COUNT_W-1:0]  o_sample_count,
  output logic                o_seq_err,
  output logic                o_busy
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST    = CNT_W'(REQ_PULSE - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req;
  logic                r_valid;
  logic [DATA_W-1:0]   r_error;
  logic                r_over;
  logic                r_under;
  logic [COUNT_W-1:0]  r_count;
  logic                r_seq_err;
  logic                r_busy;
  logic [STATUS_W-1:0] r_prev_stat;
  logic                r_have_prev;

  logic [DATA_W-1:0]   w_err;
  logic                w_over;
  logic                w_under;

  adc_err_sat #(
    .DATA_W    (DATA_W),
    .ERR_LIMIT (ERR_LIMIT)
  ) u_err_sat (
    .i_v_actual (i_v_actual),
    .i_v_signal (i_v_signal),
    .o_error    (w_err),
    .o_over     (w_over),
    .o_under    (w_under)
  );

  // Main FSM; every output is a register updated alongside the state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_valid     <= 1'b0;
      r_error     <= '0;
      r_over      <= 1'b0;
      r_under     <= 1'b0;
      r_count     <= '0;
      r_seq_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_prev_stat <= '0;
      r_have_prev <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_enable) begin
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= ST_CAPTURE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          r_error <= w_err;
          r_over  <= w_over;
          r_under <= w_under;
          r_valid <= 1'b1;
          // The first sample of a run only seeds the sequence reference.
          if (r_have_prev && (i_stim_state != status_next(r_prev_stat))) begin
            r_seq_err <= 1'b1;
          end
          r_prev_stat <= i_stim_state;
          r_have_prev <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_valid && i_fwd_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + COUNT_W'(1);
            if (i_enable) begin
              r_state <= ST_REQ;
              r_req   <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_have_prev <= 1'b0;
            end
          end
        end
        ST_REQ: begin
          if (r_cnt == REQ_LAST) begin
            r_req   <= 1'b0;
            r_state <= ST_SETTLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_next     = r_req;
  assign o_fwd_valid    = r_valid;
  assign o_fwd_error    = r_error;
  assign o_fwd_over     = r_over;
  assign o_fwd_under    = r_under;
  assign o_sample_count = r_count;
  assign o_seq_err      = r_seq_err;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_adc_forward_ctrl.sv
// Directed bench for adc_forward_ctrl: one task per scenario, expected values
// computed by hand from the default parameters (SETTLE 4, REQ_PULSE 2, limit 4).
module tb_adc_forward_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] v_actual;
  logic [15:0] v_signal;
  logic [1:0]  stim_state;
  logic        req_next;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [15:0] fwd_error;
  logic        fwd_over;
  logic        fwd_under;
  logic [7:0]  sample_count;
  logic        seq_err;
  logic        busy;

  int n_pass;
  int n_total;

  adc_forward_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_v_actual     (v_actual),
    .i_v_signal     (v_signal),
    .i_stim_state   (stim_state),
    .o_req_next     (req_next),
    .o_fwd_valid    (fwd_valid),
    .i_fwd_ready    (fwd_ready),
    .o_fwd_error    (fwd_error),
    .o_fwd_over     (fwd_over),
    .o_fwd_under    (fwd_under),
    .o_sample_count (sample_count),
    .o_seq_err      (seq_err),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; fwd_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (fwd_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; fwd_ready = 1'b0;
    step(); step();
    n_total++; if ({req_next, fwd_valid, busy, seq_err} !== 4'b0000) $display("FAIL rst_flags got %b exp 0000", {req_next, fwd_valid, busy, seq_err}); else n_pass++;
    n_total++; if (sample_count !== 8'd0) $display("FAIL rst_count got %0d exp 0", sample_count); else n_pass++;
    n_total++; if (fwd_error !== 16'h0000) $display("FAIL rst_error got %h exp 0000", fwd_error); else n_pass++;
    rst_n = 1'b1; fwd_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_total++; if (sample_count !== 8'd0 || busy !== 1'b0) $display("FAIL ready_idle got count %0d busy %b exp 0 0", sample_count, busy); else n_pass++;
    fwd_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] a_tab [5] = '{16'd1, 16'd6, 16'd6, 16'd4, 16'd9};
    logic [15:0] s_tab [5] = '{16'd1, 16'd2, 16'd1, 16'd1, 16'd9};
    logic [15:0] e_tab [5] = '{16'd0, 16'd4, 16'd5, 16'd3, 16'd0};
    logic        o_tab [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int cyc;
    apply_reset();
    enable = 1'b1; fwd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v_actual = a_tab[i]; v_signal = s_tab[i]; stim_state = 2'(i);
      wait_valid(cyc);
      if (i == 0) begin
        n_total++; if (cyc !== 6) $display("FAIL latency got %0d exp 6", cyc); else n_pass++;
      end
      n_total++; if (fwd_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b exp 1", i, fwd_valid); else n_pass++;
      n_total++; if (fwd_error !== e_tab[i]) $display("FAIL stream_err[%0d] got %h exp %h", i, fwd_error, e_tab[i]); else n_pass++;
      n_total++; if (fwd_over !== o_tab[i] || fwd_under !== 1'b0) $display("FAIL stream_flags[%0d] got %b%b exp %b0", i, fwd_over, fwd_under, o_tab[i]); else n_pass++;
      step();
      if (i == 3) begin
        n_total++; if (sample_count !== 8'd4) $display("FAIL stream_count4 got %0d exp 4", sample_count); else n_pass++;
      end
    end
    n_total++; if (seq_err !== 1'b0) $display("FAIL stream_seq got %b exp 0", seq_err); else n_pass++;
    n_total++; if (sample_count !== 8'd5) $display("FAIL stream_count5 got %0d exp 5", sample_count); else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_saturation();
    int cyc;
    apply_reset();
    enable = 1'b1; fwd_ready = 1'b0;
    v_actual = 16'hFFFF; v_signal = 16'h0000; stim_state = 2'd0;
    wait_valid(cyc);
    n_total++; if (fwd_error !== 16'h7FFF || fwd_over !== 1'b1 || fwd_under !== 1'b0) $display("FAIL sat_pos got %h o%b u%b exp 7fff o1 u0", fwd_error, fwd_over, fwd_under); else n_pass++;
    v_actual = 16'h0000; v_signal = 16'hFFFF; stim_state = 2'd1;
    fwd_ready = 1'b1; step(); fwd_ready = 1'b0;
    wait_valid(cyc);
    n_total++; if (fwd_error !== 16'h8000 || fwd_over !== 1'b0 || fwd_under !== 1'b1) $display("FAIL sat_neg got %h o%b u%b exp 8000 o0 u1", fwd_error, fwd_over, fwd_under); else n_pass++;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit stable;
    apply_reset();
    enable = 1'b1; fwd_ready = 1'b0;
    v_actual = 16'd10; v_signal = 16'd3; stim_state = 2'd0;
    wait_valid(cyc);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fwd_valid !== 1'b1 || fwd_error !== 16'd7 || fwd_over !== 1'b1 || req_next !== 1'b0) stable = 1'b0;
    end
    n_total++; if (stable !== 1'b1) $display("FAIL bp_stable got v%b e%h r%b exp v1 e0007 r0", fwd_valid, fwd_error, req_next); else n_pass++;
    n_total++; if (sample_count !== 8'd0) $display("FAIL bp_count0 got %0d exp 0", sample_count); else n_pass++;
    fwd_ready = 1'b1; step(); fwd_ready = 1'b0;
    n_total++; if (fwd_valid !== 1'b0 || sample_count !== 8'd1) $display("FAIL bp_accept got v%b c%0d exp v0 c1", fwd_valid, sample_count); else n_pass++;
    n_total++; if (req_next !== 1'b1) $display("FAIL bp_req1 got %b exp 1", req_next); else n_pass++;
    step();
    n_total++; if (req_next !== 1'b1) $display("FAIL bp_req2 got %b exp 1", req_next); else n_pass++;
    step();
    n_total++; if (req_next !== 1'b0 || busy !== 1'b1 || sample_count !== 8'd1) $display("FAIL bp_req_end got r%b b%b c%0d exp r0 b1 c1", req_next, busy, sample_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    apply_reset();
    enable = 1'b1; fwd_ready = 1'b1;
    v_actual = 16'd2; v_signal = 16'd2; stim_state = 2'd0;
    wait_valid(cyc);
    step();
    n_total++; if (req_next !== 1'b1) $display("FAIL mid_req_pre got %b exp 1", req_next); else n_pass++;
    rst_n = 1'b0; step();
    n_total++; if ({req_next, fwd_valid, busy} !== 3'b000 || sample_count !== 8'd0) $display("FAIL mid_req_rst got r%b v%b b%b c%0d exp 0 0 0 0", req_next, fwd_valid, busy, sample_count); else n_pass++;
    rst_n = 1'b1; fwd_ready = 1'b0;
    wait_valid(cyc);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    n_total++; if (fwd_valid !== 1'b0 || sample_count !== 8'd0) $display("FAIL mid_hs_rst got v%b c%0d exp v0 c0", fwd_valid, sample_count); else n_pass++;
  endtask

  task automatic test_seq_fault();
    int cyc;
    apply_reset();
    enable = 1'b1; fwd_ready = 1'b0;
    v_actual = 16'd5; v_signal = 16'd5; stim_state = 2'd1;
    wait_valid(cyc);
    n_total++; if (seq_err !== 1'b0) $display("FAIL seq_first got %b exp 0", seq_err); else n_pass++;
    fwd_ready = 1'b1; step(); fwd_ready = 1'b0;
    wait_valid(cyc);
    n_total++; if (seq_err !== 1'b1) $display("FAIL seq_repeat got %b exp 1", seq_err); else n_pass++;
    stim_state = 2'd2;
    fwd_ready = 1'b1; step(); fwd_ready = 1'b0;
    wait_valid(cyc);
    n_total++; if (seq_err !== 1'b1) $display("FAIL seq_sticky got %b exp 1", seq_err); else n_pass++;
    apply_reset();
    n_total++; if (seq_err !== 1'b0) $display("FAIL seq_clear got %b exp 0", seq_err); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int cyc;
    apply_reset();
    enable = 1'b1; fwd_ready = 1'b0;
    v_actual = 16'd3; v_signal = 16'd1; stim_state = 2'd2;
    wait_valid(cyc);
    n_total++; if (fwd_error !== 16'd2) $display("FAIL drop_err got %h exp 0002", fwd_error); else n_pass++;
    enable = 1'b0; step(); step();
    fwd_ready = 1'b1; step(); fwd_ready = 1'b0;
    n_total++; if ({fwd_valid, req_next, busy} !== 3'b000 || sample_count !== 8'd1) $display("FAIL drop_idle got v%b r%b b%b c%0d exp 0 0 0 1", fwd_valid, req_next, busy, sample_count); else n_pass++;
    step(); step(); step();
    n_total++; if (req_next !== 1'b0 || busy !== 1'b0) $display("FAIL drop_stay got r%b b%b exp 0 0", req_next, busy); else n_pass++;
    stim_state = 2'd0;
    enable = 1'b1; step(); step();
    enable = 1'b0;
    wait_valid(cyc);
    n_total++; if (fwd_valid !== 1'b1) $display("FAIL drop_settle got %b exp 1", fwd_valid); else n_pass++;
    n_total++; if (seq_err !== 1'b0) $display("FAIL drop_reseed got %b exp 0", seq_err); else n_pass++;
  endtask

  task automatic test_count_wrap();
    int cyc;
    int misses;
    apply_reset();
    enable = 1'b1; fwd_ready = 1'b1;
    v_actual = 16'd8; v_signal = 16'd8;
    misses = 0;
    for (int i = 0; i < 256; i++) begin
      stim_state = 2'(i);
      wait_valid(cyc);
      if (fwd_valid !== 1'b1) misses++;
      step();
      if (i == 254) begin
        n_total++; if (sample_count !== 8'd255) $display("FAIL wrap_255 got %0d exp 255", sample_count); else n_pass++;
      end
    end
    n_total++; if (misses !== 0) $display("FAIL wrap_timeouts got %0d exp 0", misses); else n_pass++;
    n_total++; if (sample_count !== 8'd0) $display("FAIL wrap_0 got %0d exp 0", sample_count); else n_pass++;
    n_total++; if (seq_err !== 1'b0) $display("FAIL wrap_seq got %b exp 0", seq_err); else n_pass++;
    enable = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; enable = 1'b0; fwd_ready = 1'b0;
    v_actual = 16'd0; v_signal = 16'd0; stim_state = 2'd0;
    test_reset();
    test_stream();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_seq_fault();
    test_enable_drop();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
